data_mem_responder: RTL and testbench

Memory-side responder for the single-port data memory bus used by the test wrappers and the datapath. It accepts word-addressed read/write requests, applies byte-enabled writes, and returns registered read data with a one-cycle completion pulse. After every reset it zero-fills the whole array, so initiators always start from a known memory image.

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder_ram_word_array.sv | 43 ++++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package data_mem_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_LANES  = 4;
  localparam int DEF_ADDR_W = 6;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Single-port data memory bus between an initiator and the responder.
// Latency: n/a (wires only).
// Backpressure: initiator holds a request while Mem_Busy is high and drops it in the Ready cycle.
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                 Mem_Read;
  logic                 Mem_Write;
  logic [ADDR_W-1:0]    Mem_Addr;
  logic [NUM_LANES-1:0] Mem_BE;
  logic [DATA_W-1:0]    M_W_Data;
  logic [DATA_W-1:0]    M_R_Data;
  logic                 Mem_Ready;
  logic                 Mem_Err;
  logic                 Mem_Busy;

  modport master (
    output Mem_Read, Mem_Write, Mem_Addr, Mem_BE, M_W_Data,
    input  M_R_Data, Mem_Ready, Mem_Err, Mem_Busy
  );

  modport slave (
    input  Mem_Read, Mem_Write, Mem_Addr, Mem_BE, M_W_Data,
    output M_R_Data, Mem_Ready, Mem_Err, Mem_Busy
  );
endinterface

// File: rtl/data_mem_responder_ram_word_array.sv
// Word array with per-byte-lane synchronous writes and a registered read port.
// Latency: write lands at the edge; read data is valid the cycle after i_re.
// Backpressure: none; accepts a write and/or read every cycle.
module ram_word_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  input  logic [DATA_W-1:0]    i_wdat,
  input  logic                 i_re,
  input  logic [ADDR_W-1:0]    i_raddr,
  output logic [DATA_W-1:0]    o_rdat
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdat;

  // Storage is not reset; the responder's zero-fill gives it a known image.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdat[8*i +: 8];
      end
    end
  end

  // Read register only moves on a read, so it holds across writes and idles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdat <= '0;
    end else if (i_re) begin
      r_rdat <= r_mem[i_raddr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: zero-fills after reset, then serves byte-enabled writes and reads.
// Latency: Ready/Err and read data are registered, visible the cycle after accept; 2 cycles per access.
// Backpressure: requests ignored while Busy (fill) and in the Ready cycle; initiator must hold/drop accordingly.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_clr_cnt;
  logic                  r_ready;
  logic                  r_err;
  logic                  r_busy;

  logic                  w_req;
  logic                  w_rd_only;
  logic                  w_wr_only;
  logic                  w_in_idle;
  logic                  w_clear_last;
  logic [NUM_LANES-1:0]  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [DATA_W-1:0]     w_wdat;
  logic                  w_re;
  logic [DATA_W-1:0]     w_rdat;

  assign w_req        = bus.Mem_Read | bus.Mem_Write;
  assign w_rd_only    = bus.Mem_Read & ~bus.Mem_Write;
  assign w_wr_only    = bus.Mem_Write & ~bus.Mem_Read;
  assign w_in_idle    = (r_state == ST_IDLE);
  assign w_clear_last = (r_state == ST_CLEAR) && (r_clr_cnt == LAST_ADDR);

  // State register; reset restarts the fill from word 0 even mid-fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the array write-port mux: fill path in CLEAR, request path in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = '0;
    w_waddr     = bus.Mem_Addr;
    w_wdat      = bus.M_W_Data;
    w_re        = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_we    = '1;
        w_waddr = r_clr_cnt;
        w_wdat  = '0;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_RESP;
        end
        if (w_wr_only) begin
          w_we = bus.Mem_BE;
        end
        if (w_rd_only) begin
          w_re = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fill counter walks every word once per reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Registered status: completion/error pulse for the RESP cycle, busy for the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= INIT_CLEAR;
    end else begin
      r_ready <= w_in_idle & w_req;
      r_err   <= w_in_idle & bus.Mem_Read & bus.Mem_Write;
      if (w_clear_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  ram_word_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdat  (w_wdat),
    .i_re    (w_re),
    .i_raddr (bus.Mem_Addr),
    .o_rdat  (w_rdat)
  );

  assign bus.M_R_Data  = w_rdat;
  assign bus.Mem_Ready = r_ready;
  assign bus.Mem_Err   = r_err;
  assign bus.Mem_Busy  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses vs. a word-array model.
// Latency: expects Ready/data one cycle after accept, IDLE again two cycles after accept.
// Backpressure: waits out the fill and drops each request in its Ready cycle.
module tb_data_mem_responder;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(AW)) bus ();

  data_mem_responder #(.ADDR_W(AW), .INIT_CLEAR(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.Mem_Read  = 1'b0;
    bus.Mem_Write = 1'b0;
    bus.Mem_Addr  = '0;
    bus.Mem_BE    = '0;
    bus.M_W_Data  = '0;
  endtask

  // A reset wipes the memory image and the read register.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_rdat = 32'h0;
  endtask

  // Called right after reset deasserts; counts fill edges and checks Busy at each.
  task automatic wait_fill(input string tag);
    chk({tag, "_busy0"}, {31'b0, bus.Mem_Busy}, 32'd1);
    for (int n = 1; n <= DEPTH; n++) begin
      tick();
      if (n == DEPTH - 1 || n == DEPTH || n == 20)
        chk({tag, "_busy_n"}, {31'b0, bus.Mem_Busy}, (n < DEPTH) ? 32'd1 : 32'd0);
      else if (bus.Mem_Busy !== (n < DEPTH))
        chk({tag, "_busy_mid"}, {31'b0, bus.Mem_Busy}, (n < DEPTH) ? 32'd1 : 32'd0);
    end
  endtask

  // One full access from IDLE; checks the Ready cycle and the idle cycle after it.
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [31:0] wdat);
    logic exp_err;
    bus.Mem_Read  = rd;
    bus.Mem_Write = wr;
    bus.Mem_Addr  = addr;
    bus.Mem_BE    = be;
    bus.M_W_Data  = wdat;
    exp_err = rd & wr;
    if (rd && !wr) begin
      model_rdat = model_mem[addr];
    end else if (wr && !rd) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[addr][8*b +: 8] = wdat[8*b +: 8];
    end
    tick();
    idle_bus();
    chk("ready", {31'b0, bus.Mem_Ready}, 32'd1);
    chk("err", {31'b0, bus.Mem_Err}, {31'b0, exp_err});
    chk("rdat", bus.M_R_Data, model_rdat);
    tick();
    chk("ready_off", {31'b0, bus.Mem_Ready}, 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
    int            op;
    int            rdy_cnt;
    logic [5:0]    rdy_pat;

    idle_bus();
    model_reset();

    // Reset state and fill timing.
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", {31'b0, bus.Mem_Ready}, 32'd0);
    chk("rst_err", {31'b0, bus.Mem_Err}, 32'd0);
    chk("rst_rdat", bus.M_R_Data, 32'd0);
    chk("rst_busy", {31'b0, bus.Mem_Busy}, 32'd1);
    rst = 1'b0;
    wait_fill("fill");

    // Requests during Busy are ignored: hold a read through part of a fill after a reset later on.
    access(1'b1, 1'b0, 6'd0, 4'h0, 32'h0);
    access(1'b1, 1'b0, 6'd31, 4'h0, 32'h0);
    access(1'b1, 1'b0, 6'd63, 4'h0, 32'h0);

    // Full-word write then read back.
    access(1'b0, 1'b1, 6'd5, 4'hF, 32'h003C_C381);
    access(1'b1, 1'b0, 6'd5, 4'h0, 32'h0);
    chk("wr5_value", bus.M_R_Data, 32'h003C_C381);

    // Partial byte-lane write.
    access(1'b0, 1'b1, 6'd7, 4'hF, 32'hFFFF_FFFF);
    access(1'b0, 1'b1, 6'd7, 4'b0010, 32'h0000_0DB0);
    access(1'b1, 1'b0, 6'd7, 4'h0, 32'h0);
    chk("be_merge", bus.M_R_Data, 32'hFFFF_0DFF);

    // No-op write with BE=0 still completes and leaves data alone.
    access(1'b0, 1'b1, 6'd7, 4'h0, 32'h1234_5678);
    access(1'b1, 1'b0, 6'd7, 4'h0, 32'h0);

    // Both requests high: error, no access, read data holds.
    access(1'b0, 1'b1, 6'd3, 4'hF, 32'hA5A5_5A5A);
    access(1'b1, 1'b0, 6'd5, 4'h0, 32'h0);
    access(1'b1, 1'b1, 6'd3, 4'hF, 32'h1111_2222);
    chk("both_hold", bus.M_R_Data, 32'h003C_C381);
    access(1'b1, 1'b0, 6'd3, 4'h0, 32'h0);
    chk("both_nowr", bus.M_R_Data, 32'hA5A5_5A5A);

    // Read held high for 6 cycles: accepts on alternate edges.
    bus.Mem_Read = 1'b1;
    bus.Mem_Addr = 6'd1;
    rdy_cnt = 0;
    rdy_pat = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      rdy_pat[c] = bus.Mem_Ready;
      if (bus.Mem_Ready) rdy_cnt++;
    end
    idle_bus();
    model_rdat = model_mem[1];
    chk("hold_cnt", rdy_cnt, 32'd3);
    chk("hold_pat", {26'b0, rdy_pat}, 32'b010101);
    chk("hold_rdat", bus.M_R_Data, model_rdat);
    tick();

    // Randomized accesses against the model.
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      if (op == 0)      access(1'b1, 1'b1, a, be, d);
      else if (op <= 4) access(1'b1, 1'b0, a, be, d);
      else              access(1'b0, 1'b1, a, be, d);
    end

    // Reset mid-fill restarts the fill from word 0.
    access(1'b0, 1'b1, 6'd2, 4'hF, 32'h0000_000F);
    access(1'b1, 1'b0, 6'd2, 4'h0, 32'h0);
    chk("pre_rst_w2", bus.M_R_Data, 32'h0000_000F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    // A request held during the fill must not be answered.
    bus.Mem_Read = 1'b1;
    bus.Mem_Addr = 6'd2;
    tick();
    chk("busy_noready", {31'b0, bus.Mem_Ready}, 32'd0);
    idle_bus();
    rst = 1'b1;
    tick();
    model_reset();
    chk("rst2_rdat", bus.M_R_Data, 32'd0);
    rst = 1'b0;
    wait_fill("refill");
    access(1'b1, 1'b0, 6'd2, 4'h0, 32'h0);
    chk("post_rst_w2", bus.M_R_Data, 32'h0);
    access(1'b1, 1'b0, 6'd5, 4'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
